// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the priority interrupt controller: register
// offsets, the "no candidate" id and the controller state encoding.
package int_ctrl_pkg;

    localparam logic [1:0] INT_ENABLE = 2'd0;
    localparam logic [1:0] INT_MODE   = 2'd1;
    localparam logic [1:0] INT_CLAIM  = 2'd2;
    localparam logic [1:0] INT_EOI    = 2'd3;

    localparam logic [4:0] INT_NONE   = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVICE,
        ST_NESTED
    } int_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder with a valid flag. idx is INT_NONE
// when no request bit is set.
module prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [4:0]   idx,
    output logic         valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        idx   = INT_NONE;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 5'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Priority interrupt controller feeding one CP0 HWInt line. Sources are
// individually enabled and set to edge or level mode; an in-service vector
// ensures only a strictly higher-priority source can preempt a handler.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC      = 8,
    parameter int HWINT_LINE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [5:0]       hwint
);

    localparam logic [N_SRC-1:0] ONE = 1;

    logic [N_SRC-1:0] enable, mode, epend, isr, src_d;
    logic             hwint_q;
    int_state_e       state;

    logic [N_SRC-1:0] rise, pend, below_lvl, claim_mask, eoi_mask;
    logic [N_SRC-1:0] isr_n, epend_n;
    logic [4:0]       lvl_idx, lvl, cand_idx;
    logic             lvl_valid, cand_valid, claim, eoi_en;
    logic             unused_wdata;

    // Upper write-data bits are don't-care for the narrow registers.
    assign unused_wdata = ^wdata;

    assign rise = src_irq & ~src_d;
    assign pend = ((mode & epend) | (~mode & src_irq)) & enable;

    prio_enc #(.W(N_SRC)) u_lvl_enc (
        .req   (isr),
        .idx   (lvl_idx),
        .valid (lvl_valid)
    );

    assign lvl = lvl_valid ? lvl_idx : 5'(N_SRC);

    // Only sources strictly above the current service level may interrupt.
    always_comb begin
        below_lvl = '0;
        for (int i = 0; i < N_SRC; i++) begin
            below_lvl[i] = (i < int'(lvl));
        end
    end

    prio_enc #(.W(N_SRC)) u_cand_enc (
        .req   (pend & below_lvl),
        .idx   (cand_idx),
        .valid (cand_valid)
    );

    // A write on the same cycle as a read suppresses the claim side effect;
    // an EOI with nothing in service is a no-op.
    assign claim  = re && !we && (addr == INT_CLAIM) && cand_valid;
    assign eoi_en = we && (addr == INT_EOI) && (state != ST_IDLE);

    // Out-of-range ids shift out to zero, and ids not in service are masked.
    assign claim_mask = claim  ? (ONE << cand_idx)        : '0;
    assign eoi_mask   = eoi_en ? ((ONE << wdata[4:0]) & isr) : '0;

    // A new edge wins over the clear from its own claim.
    assign epend_n = (epend & ~claim_mask) | rise;
    assign isr_n   = (isr | claim_mask) & ~eoi_mask;

    // Register file, edge capture, service tracking and controller state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable  <= '0;
            mode    <= '0;
            epend   <= '0;
            isr     <= '0;
            src_d   <= '0;
            hwint_q <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            src_d   <= src_irq;
            epend   <= epend_n;
            isr     <= isr_n;
            hwint_q <= cand_valid;
            if (we && addr == INT_ENABLE) enable <= wdata[N_SRC-1:0];
            if (we && addr == INT_MODE)   mode   <= wdata[N_SRC-1:0];
            if (isr_n == '0)
                state <= ST_IDLE;
            else if ((isr_n & (isr_n - ONE)) == '0)
                state <= ST_SERVICE;
            else
                state <= ST_NESTED;
        end
    end

    // Combinational read mux; unused upper bits read as zero.
    always_comb begin
        rdata = '0;
        case (addr)
            INT_ENABLE: rdata[N_SRC-1:0] = enable;
            INT_MODE:   rdata[N_SRC-1:0] = mode;
            INT_CLAIM:  rdata[4:0]       = cand_idx;
            default:    rdata            = '0;
        endcase
    end

    // Only the configured HWInt bit is ever driven.
    always_comb begin
        hwint             = '0;
        hwint[HWINT_LINE] = hwint_q;
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: edge and level delivery, nesting, masking by
// the in-service level, ignored EOIs, claim/edge collision and async reset.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  src_irq = '0;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [5:0]  hwint;

    int n_cmp = 0;
    int n_bad = 0;

    int_ctrl #(.N_SRC(8), .HWINT_LINE(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .addr    (addr),
        .we      (we),
        .re      (re),
        .wdata   (wdata),
        .rdata   (rdata),
        .hwint   (hwint)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_claim(output logic [31:0] d);
        addr = INT_CLAIM;
        re   = 1'b1;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        re   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        #12;
        addr = INT_ENABLE;
        #1;
        n_cmp++;
        if (hwint !== 6'b0) begin n_bad++; $display("FAIL reset_hwint got %b want 000000", hwint); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        tick();
        reset = 1'b0;
        tick();
        bus_read(INT_MODE, d);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL reset_mode got %h want 0", d); end
    endtask

    task automatic test_edge_basic();
        logic [31:0] d;
        bus_write(INT_ENABLE, 32'h05);
        bus_write(INT_MODE, 32'h01);
        bus_read(INT_ENABLE, d);
        n_cmp++;
        if (d !== 32'h05) begin n_bad++; $display("FAIL enable_rb got %h want 05", d); end
        bus_read(INT_MODE, d);
        n_cmp++;
        if (d !== 32'h01) begin n_bad++; $display("FAIL mode_rb got %h want 01", d); end
        src_irq[0] = 1'b1;
        tick();
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL edge_lat1 got %b want 000000", hwint); end
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL edge_lat2 got %b want 000100", hwint); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL edge_claim got %h want 0", d); end
        tick();
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL edge_drop got %b want 000000", hwint); end
        src_irq[0] = 1'b0;
        bus_write(INT_EOI, 32'd0);
        tick();
    endtask

    task automatic test_nested();
        logic [31:0] d;
        src_irq[2] = 1'b1;
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL level_lat got %b want 000100", hwint); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'd2) begin n_bad++; $display("FAIL nest_claim2 got %h want 2", d); end
        src_irq[0] = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL nest_hwint got %b want 000100", hwint); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL nest_claim0 got %h want 0", d); end
        n_cmp++;
        if (dut.isr !== 8'h05) begin n_bad++; $display("FAIL nest_isr got %h want 05", dut.isr); end
        n_cmp++;
        if (dut.state !== ST_NESTED) begin n_bad++; $display("FAIL nest_state got %0d want %0d", dut.state, ST_NESTED); end
        src_irq[0] = 1'b0;
        bus_write(INT_EOI, 32'd0);
        n_cmp++;
        if (dut.state !== ST_SERVICE) begin n_bad++; $display("FAIL eoi0_state got %0d want %0d", dut.state, ST_SERVICE); end
        src_irq[2] = 1'b0;
        bus_write(INT_EOI, 32'd2);
        n_cmp++;
        if (dut.isr !== 8'h00) begin n_bad++; $display("FAIL eoi2_isr got %h want 00", dut.isr); end
        n_cmp++;
        if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL eoi2_state got %0d want %0d", dut.state, ST_IDLE); end
        tick();
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL nest_idle_hwint got %b want 000000", hwint); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        src_irq[0] = 1'b1;
        tick();
        tick();
        do_claim(d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL mask_claim0 got %h want 0", d); end
        src_irq[2] = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL mask_hwint got %b want 000000", hwint); end
        bus_write(INT_EOI, 32'd0);
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL unmask_hwint got %b want 000100", hwint); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'd2) begin n_bad++; $display("FAIL unmask_claim got %h want 2", d); end
        src_irq = '0;
        bus_write(INT_EOI, 32'd2);
        tick();
    endtask

    task automatic test_empty_and_ignored_eoi();
        logic [31:0] d;
        do_claim(d);
        n_cmp++;
        if (d !== 32'h1F) begin n_bad++; $display("FAIL empty_claim got %h want 1f", d); end
        n_cmp++;
        if (dut.isr !== 8'h00) begin n_bad++; $display("FAIL empty_isr got %h want 00", dut.isr); end
        bus_write(INT_EOI, 32'd7);
        n_cmp++;
        if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL eoi7_idle got %0d want %0d", dut.state, ST_IDLE); end
        src_irq[2] = 1'b1;
        tick();
        do_claim(d);
        n_cmp++;
        if (d !== 32'd2) begin n_bad++; $display("FAIL ign_claim2 got %h want 2", d); end
        bus_write(INT_EOI, 32'd31);
        n_cmp++;
        if (dut.isr !== 8'h04) begin n_bad++; $display("FAIL eoi31_isr got %h want 04", dut.isr); end
        bus_write(INT_EOI, 32'd7);
        n_cmp++;
        if (dut.isr !== 8'h04) begin n_bad++; $display("FAIL eoi7_isr got %h want 04", dut.isr); end
        src_irq[2] = 1'b0;
        bus_write(INT_EOI, 32'd2);
        tick();
    endtask

    task automatic test_edge_during_claim();
        logic [31:0] d;
        src_irq[0] = 1'b1;
        tick();
        src_irq[0] = 1'b0;
        tick();
        tick();
        src_irq[0] = 1'b1;
        do_claim(d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL coll_claim got %h want 0", d); end
        n_cmp++;
        if (dut.epend[0] !== 1'b1) begin n_bad++; $display("FAIL coll_epend got %b want 1", dut.epend[0]); end
        tick();
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL coll_masked got %b want 000000", hwint); end
        src_irq[0] = 1'b0;
        bus_write(INT_EOI, 32'd0);
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL coll_redeliver got %b want 000100", hwint); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'd0) begin n_bad++; $display("FAIL coll_reclaim got %h want 0", d); end
        bus_write(INT_EOI, 32'd0);
        tick();
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] d;
        bus_write(INT_ENABLE, 32'h07);
        src_irq[2] = 1'b1;
        tick();
        do_claim(d);
        n_cmp++;
        if (d !== 32'd2) begin n_bad++; $display("FAIL rst_claim2 got %h want 2", d); end
        src_irq[1] = 1'b1;
        tick();
        tick();
        do_claim(d);
        n_cmp++;
        if (d !== 32'd1) begin n_bad++; $display("FAIL rst_claim1 got %h want 1", d); end
        src_irq[0] = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (hwint !== 6'b000100) begin n_bad++; $display("FAIL rst_pre_hwint got %b want 000100", hwint); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (hwint !== 6'b000000) begin n_bad++; $display("FAIL rst_async_hwint got %b want 000000", hwint); end
        n_cmp++;
        if (dut.isr !== 8'h00) begin n_bad++; $display("FAIL rst_isr got %h want 00", dut.isr); end
        src_irq = '0;
        tick();
        reset = 1'b0;
        tick();
        bus_read(INT_ENABLE, d);
        n_cmp++;
        if (d !== 32'h0) begin n_bad++; $display("FAIL rst_enable got %h want 0", d); end
        do_claim(d);
        n_cmp++;
        if (d !== 32'h1F) begin n_bad++; $display("FAIL rst_claim got %h want 1f", d); end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_nested();
        test_masked();
        test_empty_and_ignored_eoi();
        test_edge_during_claim();
        test_reset_mid_service();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
